rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Write-port arbiter for the CPU's 8x16 register file, sharing its single write port (`regWrite`, `rd`, `write_data`) between the CPU writeback stage and the cryptographic accelerator. Accelerator writes are buffered in a 2-entry FIFO. CPU writeback has priority, bounded by a starvation counter that forces an accelerator grant and stalls the CPU for one cycle. It sits between the writeback stage, the accelerator result path and `regFile`.

## Interface
- `STARVE_LIMIT`, 4: consecutive CPU-won cycles with a pending accelerator entry before that entry is forced through; legal range 1-15.
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst_n` in 1: reset; one clock, reset asynchronous and active-low.
- `cpu_we` in 1: CPU writeback request this cycle.
- `cpu_rd` in 3: CPU destination register.
- `cpu_wdata` in 16: CPU write data.
- `cpu_stall` out 1: CPU write not taken this cycle; CPU holds `cpu_we`, `cpu_rd` and `cpu_wdata` into the next cycle.
- `acc_valid` in 1: accelerator write offered.
- `acc_ready` out 1: FIFO can accept; transfer occurs when `acc_valid & acc_ready` at a rising edge.
- `acc_rd` in 3: accelerator destination register.
- `acc_wdata` in 16: accelerator write data.
- `rf_regWrite` out 1: register-file write enable.
- `rf_rd` out 3: register-file destination.
- `rf_write_data` out 16: register-file write data.
- `grant_acc` out 1: 1 when the FIFO head drives the port this cycle.
- `acc_pending` out 1: FIFO non-empty.

## Operation
- State:
  - 2-entry FIFO of {rd[2:0], data[15:0]} with pointers and an occupancy count of 0-2.
  - 4-bit starvation counter `starve`.
- Grant, combinational each cycle:
  - FIFO empty: the CPU owns the port. `rf_regWrite = cpu_we`, `rf_rd = cpu_rd`, `rf_write_data = cpu_wdata`, `grant_acc = 0`.
  - FIFO non-empty and (`cpu_we = 0` or `starve == STARVE_LIMIT`): the FIFO head drives the port with `rf_regWrite = 1` and `grant_acc = 1`; the head is popped at the edge.
  - Otherwise the CPU is granted.
- `cpu_stall = cpu_we & grant_acc`.
- `starve` update:
  - Cleared to 0 on any accelerator grant or when the FIFO is empty.
  - Incremented when the CPU is granted with the FIFO non-empty.
  - Saturates at `STARVE_LIMIT`.
- `acc_ready = (count < 2)`; it does not account for a same-cycle pop.
  - When count is 2, a pop frees space visible next cycle.
  - When count is 1, push and pop in the same cycle leave count at 1.
- No hazard or ordering check between requesters: writes to the same register land in grant order, and the later write wins.
- While `rst_n` is low, `rf_regWrite` is forced to 0 and `cpu_stall` to 0.

## Timing
- Reset values:
  - FIFO empty, `starve = 0`.
  - `acc_ready = 1`, `acc_pending = 0`, `grant_acc = 0`.
  - `rf_regWrite = 0`, `cpu_stall = 0`.
  - `rf_rd` and `rf_write_data` follow the CPU inputs.
- CPU path has zero latency: a granted `cpu_we` reaches the register file in the same cycle.
- Accelerator path: a write accepted at edge N is eligible for grant in cycle N+1 at the earliest.
- Maximum wait for the FIFO head under continuous CPU writes is `STARVE_LIMIT` cycles, then one forced grant. With 2 entries, worst-case drain is 2*(`STARVE_LIMIT`+1) cycles.
- `cpu_stall` lasts exactly one cycle per forced grant. `starve` returns to 0, so back-to-back forced grants require a full `STARVE_LIMIT` again.
- Asynchronous reset mid-operation discards all FIFO entries; buffered accelerator writes are lost and the accelerator must re-issue them.

## Test plan
- Reset, then `cpu_we=1, cpu_rd=3, cpu_wdata=16'hBEEF` -> same cycle `rf_regWrite=1, rf_rd=3, rf_write_data=16'hBEEF`, `cpu_stall=0`.
- CPU idle, accelerator pushes (5, 16'h1234) at edge N -> cycle N+1 `grant_acc=1, rf_rd=5, rf_write_data=16'h1234`; `acc_pending=0` after edge N+1.
- `STARVE_LIMIT=4`, `cpu_we` held high, one accelerator entry queued -> 4 CPU-granted cycles, then 1 cycle with `grant_acc=1, cpu_stall=1`, then CPU resumes with its held write.
- Accelerator pushes 3 back-to-back while CPU is busy -> `acc_ready=0` after the second push; the third is accepted only after the first forced pop; all three reach the register file in order.
- Same-register race: accelerator entry to R2=16'h00AA pending while CPU writes R2=16'h0055 continuously -> final R2 is the write granted last, matching the grant sequence.
- `rst_n` asserted low with 2 entries queued -> immediately `acc_pending=0, rf_regWrite=0, acc_ready=1`; no queued write appears after release.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// rf_write_arbiter_if: the CPU writeback, accelerator and register-file write signals
// grouped together. The master modport is the requester side; the slave modport is the arbiter.
interface rf_write_arbiter_if;
  logic        cpu_we;
  logic [2:0]  cpu_rd;
  logic [15:0] cpu_wdata;
  logic        cpu_stall;

  logic        acc_valid;
  logic        acc_ready;
  logic [2:0]  acc_rd;
  logic [15:0] acc_wdata;

  logic        rf_regWrite;
  logic [2:0]  rf_rd;
  logic [15:0] rf_write_data;
  logic        grant_acc;
  logic        acc_pending;

  modport master (
    output cpu_we, cpu_rd, cpu_wdata, acc_valid, acc_rd, acc_wdata,
    input  cpu_stall, acc_ready, rf_regWrite, rf_rd, rf_write_data,
           grant_acc, acc_pending
  );

  modport slave (
    input  cpu_we, cpu_rd, cpu_wdata, acc_valid, acc_rd, acc_wdata,
    output cpu_stall, acc_ready, rf_regWrite, rf_rd, rf_write_data,
           grant_acc, acc_pending
  );
endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// rf_write_arbiter: shares the register-file write port between CPU writeback (priority)
// and a 2-entry accelerator FIFO, with a starvation counter that forces accelerator grants.
module rf_write_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  rf_write_arbiter_if.slave   bus
);

  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

  logic [18:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [3:0]  starve;

  logic        fifo_empty;
  logic        grant;
  logic        push;
  logic        pop;
  logic [18:0] head;

  assign fifo_empty = (count == 2'd0);
  assign head       = fifo_mem[rd_ptr];

  // The head wins when the CPU is idle or has out-waited its starvation budget.
  assign grant = !fifo_empty && (!bus.cpu_we || (starve == LIMIT));
  assign pop   = grant;
  assign push  = bus.acc_valid && bus.acc_ready;

  assign bus.acc_ready     = (count != 2'd2);
  assign bus.acc_pending   = !fifo_empty;
  assign bus.grant_acc     = grant;
  assign bus.cpu_stall     = rst_n && bus.cpu_we && grant;
  assign bus.rf_regWrite   = rst_n && (grant || bus.cpu_we);
  assign bus.rf_rd         = grant ? head[18:16] : bus.cpu_rd;
  assign bus.rf_write_data = grant ? head[15:0]  : bus.cpu_wdata;

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.acc_rd, bus.acc_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      starve <= 4'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (grant || fifo_empty) begin
        starve <= 4'd0;
      end else if (starve != LIMIT) begin
        starve <= starve + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// tb_rf_write_arbiter: directed vectors with hand-computed expectations for rf_write_arbiter.
module tb_rf_write_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rf_write_arbiter_if bus ();

  rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic we, input logic [2:0] rd, input logic [15:0] data);
    bus.cpu_we    = we;
    bus.cpu_rd    = rd;
    bus.cpu_wdata = data;
  endtask

  task automatic drive_acc(input logic valid, input logic [2:0] rd, input logic [15:0] data);
    bus.acc_valid = valid;
    bus.acc_rd    = rd;
    bus.acc_wdata = data;
  endtask

  // CPU hammers R2 while an accelerator write to R2 is queued; a shadow R2 follows the port.
  task automatic run_race(input int stop_cyc, input int exp_gcyc, input logic [15:0] exp_final,
                          input string tag);
    logic [15:0] r2;
    int          gcyc;
    r2   = 16'h0000;
    gcyc = -1;
    drive_cpu(1'b1, 3'd2, 16'h0055);
    for (int cyc = 0; cyc < 10; cyc++) begin
      drive_acc(cyc == 0, 3'd2, 16'h00AA);
      if (cyc >= stop_cyc) drive_cpu(1'b0, 3'd0, 16'h0000);
      @(negedge clk);
      if (bus.rf_regWrite && bus.rf_rd == 3'd2) r2 = bus.rf_write_data;
      if (bus.grant_acc) gcyc = cyc;
      next_cycle();
    end
    drive_acc(1'b0, 3'd0, 16'h0000);
    drive_cpu(1'b0, 3'd0, 16'h0000);
    check_eq({tag, "_grant_cycle"}, gcyc, exp_gcyc);
    check_eq({tag, "_final_r2"}, {16'h0, r2}, {16'h0, exp_final});
  endtask

  int           gcyc_q [$];
  logic [2:0]   grd_q  [$];
  logic [15:0]  gdat_q [$];
  int           c_acc;
  bit           c_done;
  int           writes_after_reset;
  int           exp_gcyc [3];
  logic [2:0]   exp_grd  [3];
  logic [15:0]  exp_gdat [3];

  initial begin
    // Reset, with the CPU requesting so the write-enable forcing is visible
    rst_n = 1'b0;
    drive_cpu(1'b1, 3'd3, 16'hCAFE);
    drive_acc(1'b0, 3'd0, 16'h0000);
    #2;
    @(negedge clk);
    check_eq("rst_acc_ready", bus.acc_ready, 1);
    check_eq("rst_acc_pending", bus.acc_pending, 0);
    check_eq("rst_grant_acc", bus.grant_acc, 0);
    check_eq("rst_regWrite", bus.rf_regWrite, 0);
    check_eq("rst_cpu_stall", bus.cpu_stall, 0);
    check_eq("rst_rf_rd_follow", bus.rf_rd, 3);
    check_eq("rst_wdata_follow", bus.rf_write_data, 16'hCAFE);
    next_cycle();
    rst_n = 1'b1;

    // Zero-latency CPU write
    drive_cpu(1'b1, 3'd3, 16'hBEEF);
    @(negedge clk);
    check_eq("cpu_regWrite", bus.rf_regWrite, 1);
    check_eq("cpu_rf_rd", bus.rf_rd, 3);
    check_eq("cpu_wdata", bus.rf_write_data, 16'hBEEF);
    check_eq("cpu_stall", bus.cpu_stall, 0);
    check_eq("cpu_grant_acc", bus.grant_acc, 0);
    next_cycle();

    // CPU idle, single accelerator write
    drive_cpu(1'b0, 3'd0, 16'h0000);
    drive_acc(1'b1, 3'd5, 16'h1234);
    @(negedge clk);
    check_eq("acc_ready_empty", bus.acc_ready, 1);
    check_eq("idle_regWrite", bus.rf_regWrite, 0);
    check_eq("idle_grant", bus.grant_acc, 0);
    next_cycle();
    drive_acc(1'b0, 3'd0, 16'h0000);
    @(negedge clk);
    check_eq("acc_grant", bus.grant_acc, 1);
    check_eq("acc_regWrite", bus.rf_regWrite, 1);
    check_eq("acc_rf_rd", bus.rf_rd, 5);
    check_eq("acc_wdata", bus.rf_write_data, 16'h1234);
    check_eq("acc_pending_before", bus.acc_pending, 1);
    check_eq("acc_no_stall", bus.cpu_stall, 0);
    next_cycle();
    @(negedge clk);
    check_eq("acc_pending_after", bus.acc_pending, 0);
    check_eq("acc_grant_after", bus.grant_acc, 0);
    next_cycle();

    // Starvation: four CPU cycles, one forced grant, CPU resumes
    drive_cpu(1'b1, 3'd1, 16'h1111);
    drive_acc(1'b1, 3'd6, 16'h6666);
    next_cycle();
    drive_acc(1'b0, 3'd0, 16'h0000);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check_eq("starve_cpu_grant", bus.grant_acc, 0);
      check_eq("starve_cpu_rd", bus.rf_rd, 1);
      check_eq("starve_pending", bus.acc_pending, 1);
      next_cycle();
    end
    @(negedge clk);
    check_eq("forced_grant", bus.grant_acc, 1);
    check_eq("forced_stall", bus.cpu_stall, 1);
    check_eq("forced_rd", bus.rf_rd, 6);
    check_eq("forced_wdata", bus.rf_write_data, 16'h6666);
    next_cycle();
    @(negedge clk);
    check_eq("resume_grant", bus.grant_acc, 0);
    check_eq("resume_stall", bus.cpu_stall, 0);
    check_eq("resume_regWrite", bus.rf_regWrite, 1);
    check_eq("resume_rd", bus.rf_rd, 1);
    check_eq("resume_wdata", bus.rf_write_data, 16'h1111);
    check_eq("resume_pending", bus.acc_pending, 0);
    next_cycle();

    // Three back-to-back accelerator pushes against a busy CPU
    drive_cpu(1'b1, 3'd7, 16'h7777);
    c_acc  = -1;
    c_done = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc == 0)      drive_acc(1'b1, 3'd1, 16'hA001);
      else if (cyc == 1) drive_acc(1'b1, 3'd2, 16'hB002);
      else if (!c_done)  drive_acc(1'b1, 3'd3, 16'hC003);
      else               drive_acc(1'b0, 3'd0, 16'h0000);
      @(negedge clk);
      if (cyc == 2) check_eq("full_not_ready", bus.acc_ready, 0);
      if (cyc >= 2 && !c_done && bus.acc_ready) begin
        c_done = 1'b1;
        c_acc  = cyc;
      end
      if (bus.grant_acc) begin
        gcyc_q.push_back(cyc);
        grd_q.push_back(bus.rf_rd);
        gdat_q.push_back(bus.rf_write_data);
        check_eq("b2b_stall_with_grant", bus.cpu_stall, 1);
      end
      next_cycle();
    end
    drive_acc(1'b0, 3'd0, 16'h0000);
    exp_gcyc = '{5, 10, 15};
    exp_grd  = '{3'd1, 3'd2, 3'd3};
    exp_gdat = '{16'hA001, 16'hB002, 16'hC003};
    check_eq("b2b_third_accept_cycle", c_acc, 6);
    check_eq("b2b_grant_count", gcyc_q.size(), 3);
    for (int i = 0; i < gcyc_q.size() && i < 3; i++) begin
      check_eq("b2b_grant_cycle", gcyc_q[i], exp_gcyc[i]);
      check_eq("b2b_grant_rd", grd_q[i], exp_grd[i]);
      check_eq("b2b_grant_wdata", gdat_q[i], exp_gdat[i]);
    end

    // Same-register races: CPU writes last, then accelerator writes last
    run_race(100, 5, 16'h0055, "race_cpu_last");
    run_race(3, 3, 16'h00AA, "race_acc_last");

    // Asynchronous reset with two entries queued
    drive_cpu(1'b1, 3'd4, 16'h4444);
    drive_acc(1'b1, 3'd1, 16'h0101);
    next_cycle();
    drive_acc(1'b1, 3'd2, 16'h0202);
    next_cycle();
    drive_acc(1'b0, 3'd0, 16'h0000);
    check_eq("pre_rst_pending", bus.acc_pending, 1);
    check_eq("pre_rst_not_ready", bus.acc_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_pending", bus.acc_pending, 0);
    check_eq("async_rst_regWrite", bus.rf_regWrite, 0);
    check_eq("async_rst_ready", bus.acc_ready, 1);
    check_eq("async_rst_stall", bus.cpu_stall, 0);
    drive_cpu(1'b0, 3'd0, 16'h0000);
    next_cycle();
    rst_n = 1'b1;
    writes_after_reset = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (bus.rf_regWrite || bus.grant_acc) writes_after_reset++;
      next_cycle();
    end
    check_eq("no_write_after_reset", writes_after_reset, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
